code_gen: RTL and testbench
===========================

Name: code_gen

Overview:
- Generates the 4-digit secret code (num_1..num_4) consumed by the joystick code checker.
- Presents each digit to the display path one at a time, then arms and waits for the checker's pass_flag.
- On pass: bumps the round counter and generates a new code. On timeout: returns to idle.
- Sits between the game-control/start logic and the checker, the producer end of the code/pass interface.

Parameters:
- SHOW_CYCLES, 50_000_000: cycles each digit is displayed (1 s at 50 MHz).
- GAP_CYCLES, 12_500_000: blank cycles after each displayed digit.
- TIMEOUT_CYCLES, 500_000_000: cycles allowed in ARMED before abandoning the round.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset. Must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  request new code (level sampled each cycle)
- pass_flag  in  1  checker reports full code entered correctly
- num_1, num_2, num_3, num_4  out  3 each  code digits to checker
- code_valid  out  1  digits stable and checker armed
- show_en  out  1  display digit now
- show_digit  out  3  digit being displayed
- show_idx  out  2  index (0..3) of displayed digit
- busy  out  1  high in GEN/SHOW/GAP
- round_cnt  out  8  completed rounds, saturating
- timeout_flag  out  1  one-cycle pulse on round timeout

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, lfsr = LFSR_SEED.
  - num_1..num_4 = 0, show_idx = 0, show_digit = 0, round_cnt = 0.
  - code_valid, show_en, busy, timeout_flag = 0.
  - Reset mid-round aborts immediately, with no pulses emitted.
- LFSR:
  - 16-bit Galois, right shift, toggle mask 16'hB400 applied when the shifted-out bit is 1.
  - Advances every cycle in all states except reset.
- States: IDLE, GEN, SHOW, GAP, ARMED, DONE.
- IDLE:
  - Outputs low, except that num_x and round_cnt hold their values.
  - start=1 -> GEN next cycle, with slot index cleared.
- GEN:
  - Each cycle, if lfsr[2:0] != 0, write it to slot idx (0 -> num_1 ... 3 -> num_4) and increment idx.
  - If lfsr[2:0] == 0, no write (retry next cycle). Digits are therefore always 1..7.
  - After slot 3 is written -> SHOW, with show_idx=0 and timer=0.
- SHOW:
  - show_en=1, show_digit = num[show_idx].
  - timer == SHOW_CYCLES-1 -> GAP, timer=0.
- GAP:
  - show_en=0, show_digit=0.
  - timer == GAP_CYCLES-1: if show_idx == 3 -> ARMED with timer=0; otherwise show_idx+1 -> SHOW.
- ARMED:
  - code_valid=1, timer counts.
  - pass_flag=1 -> DONE.
  - Otherwise, start=1 -> GEN (abort and regenerate).
  - Otherwise, timer == TIMEOUT_CYCLES-1 -> IDLE with timeout_flag=1 for exactly one cycle.
- DONE (1 cycle):
  - code_valid=0.
  - round_cnt increments, saturating at 255.
  - -> GEN automatically.
- busy = 1 exactly in GEN, SHOW, GAP.
- num_1..num_4 change only in GEN. code_valid is 0 whenever any digit may change.
- Priorities in ARMED: pass_flag > start > timeout.
- Ignored inputs:
  - start in GEN/SHOW/GAP/DONE.
  - pass_flag outside ARMED.
- Timers are 32 bits. Parameters must be at least 1.

Decomposition:
- Package code_pkg:
  - state enum.
  - NUM_DIGITS = 4.
  - DIGIT_W = 3.
  - LFSR_MASK = 16'hB400.
- Sub-module lfsr16 (clk, reset, seed param, q[15:0]): free-running Galois LFSR, instantiated once.
- FSM, timer and digit registers live in code_gen.

Test Plan:
- Bench parameters: SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20. Digits are compared against a bench LFSR model (seed 16'hACE1).
1. Reset, then start pulse:
   - busy rises the cycle after start.
   - 4 digits captured, all nonzero and equal to the model.
   - show_en pattern is 4 high / 2 low, repeated 4 times, with show_idx 0,1,2,3 and show_digit = num_x.
   - code_valid rises after the 4th gap.
2. ARMED, pass_flag=1 for one cycle:
   - Next cycle is DONE: code_valid=0, round_cnt 0 -> 1.
   - Then GEN regenerates and busy=1.
3. ARMED with no input for 20 cycles:
   - timeout_flag high exactly one cycle.
   - State IDLE, code_valid=0, round_cnt unchanged.
4. ARMED, pass_flag and start high in the same cycle:
   - pass wins: round_cnt+1, one DONE cycle, then GEN.
   - No timeout_flag.
5. Preload round_cnt=255 via repeated passes:
   - A further pass leaves round_cnt=255.
6. Reset asserted during SHOW (show_idx=2):
   - Next cycle all outputs return to reset values, state IDLE.
   - A start pulse after reset release begins GEN normally.

Source files
------------

// File: rtl/code_gen_pkg.sv
// Shared types and constants for the secret-code generator.
package code_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW,
    ST_GAP,
    ST_ARMED,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 3;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

endpackage

// File: rtl/code_gen_lfsr16.sv
// Free-running 16-bit right-shift Galois LFSR, reloaded with SEED on reset.
module lfsr16
  import code_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/code_gen.sv
// Generates a 4-digit code, shows each digit in turn, then arms the checker
// and waits for pass (new round), start (regenerate) or timeout (idle).
module code_gen
  import code_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pass_flag,
  output logic [2:0] num_1,
  output logic [2:0] num_2,
  output logic [2:0] num_3,
  output logic [2:0] num_4,
  output logic       code_valid,
  output logic       show_en,
  output logic [2:0] show_digit,
  output logic [1:0] show_idx,
  output logic       busy,
  output logic [7:0] round_cnt,
  output logic       timeout_flag
);

  state_e                                   state_q, state_d;
  logic [1:0]                               idx_q, idx_d;
  logic [1:0]                               show_idx_q, show_idx_d;
  logic [31:0]                              timer_q, timer_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]       num_q, num_d;
  logic [7:0]                               round_cnt_q, round_cnt_d;
  logic                                     timeout_q, timeout_d;
  logic [15:0]                              lfsr_q;
  logic                                     unused_lfsr_hi;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:3];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    show_idx_d  = show_idx_q;
    timer_d     = timer_q;
    num_d       = num_q;
    round_cnt_d = round_cnt_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GEN;
          idx_d   = '0;
        end
      end
      ST_GEN: begin
        // A zero draw is skipped so every digit lands in 1..7.
        if (lfsr_q[2:0] != '0) begin
          num_d[idx_q] = lfsr_q[2:0];
          if (idx_q == 2'd3) begin
            state_d    = ST_SHOW;
            show_idx_d = '0;
            timer_d    = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_SHOW: begin
        if (timer_q == SHOW_CYCLES - 1) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_CYCLES - 1) begin
          timer_d = '0;
          if (show_idx_q == 2'd3) begin
            state_d = ST_ARMED;
          end else begin
            state_d    = ST_SHOW;
            show_idx_d = show_idx_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_ARMED: begin
        if (pass_flag) begin
          state_d = ST_DONE;
        end else if (start) begin
          state_d = ST_GEN;
          idx_d   = '0;
        end else if (timer_q == TIMEOUT_CYCLES - 1) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_DONE: begin
        if (round_cnt_q != 8'hFF) round_cnt_d = round_cnt_q + 8'd1;
        state_d = ST_GEN;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      show_idx_q  <= '0;
      timer_q     <= '0;
      num_q       <= '0;
      round_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      show_idx_q  <= show_idx_d;
      timer_q     <= timer_d;
      num_q       <= num_d;
      round_cnt_q <= round_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign num_1        = num_q[0];
  assign num_2        = num_q[1];
  assign num_3        = num_q[2];
  assign num_4        = num_q[3];
  assign code_valid   = (state_q == ST_ARMED);
  assign show_en      = (state_q == ST_SHOW);
  assign show_digit   = (state_q == ST_SHOW) ? num_q[show_idx_q] : '0;
  assign show_idx     = (state_q == ST_SHOW || state_q == ST_GAP) ? show_idx_q : '0;
  assign busy         = (state_q == ST_GEN) || (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign round_cnt    = round_cnt_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_code_gen.sv
// Directed self-checking bench for code_gen with short display/timeout windows.
module tb_code_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] MASK = 16'hB400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pass_flag = 1'b0;
  logic [2:0] num_1, num_2, num_3, num_4;
  logic       code_valid, show_en, busy, timeout_flag;
  logic [2:0] show_digit;
  logic [1:0] show_idx;
  logic [7:0] round_cnt;

  code_gen #(
    .SHOW_CYCLES    (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (20),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pass_flag    (pass_flag),
    .num_1        (num_1),
    .num_2        (num_2),
    .num_3        (num_3),
    .num_4        (num_4),
    .code_valid   (code_valid),
    .show_en      (show_en),
    .show_digit   (show_digit),
    .show_idx     (show_idx),
    .busy         (busy),
    .round_cnt    (round_cnt),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? MASK : 16'h0000);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_next(m_lfsr);

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_d [4];
  int exp_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected digits and GEN length, starting from the LFSR value of the first GEN cycle.
  task automatic predict(input logic [15:0] v0);
    logic [15:0] v;
    int cnt;
    v = v0;
    cnt = 0;
    exp_cyc = 0;
    while (cnt < 4 && exp_cyc < 200) begin
      exp_cyc++;
      if (v[2:0] != 3'd0) begin
        exp_d[cnt] = v[2:0];
        cnt++;
      end
      v = lfsr_next(v);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_num_1", num_1, 0);
    chk("rst_num_2", num_2, 0);
    chk("rst_num_3", num_3, 0);
    chk("rst_num_4", num_4, 0);
    chk("rst_show_idx", show_idx, 0);
    chk("rst_show_digit", show_digit, 0);
    chk("rst_round_cnt", round_cnt, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_show_en", show_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
  endtask

  // Entered on the first GEN cycle; leaves on the first ARMED cycle, or on the
  // first SHOW cycle of digit stop_idx.
  task automatic run_round(input int stop_idx);
    predict(m_lfsr);
    chk("gen_busy", busy, 1);
    for (int c = 1; c < exp_cyc; c++) begin
      tick();
      chk("gen_busy", busy, 1);
      chk("gen_show_en", show_en, 0);
      chk("gen_code_valid", code_valid, 0);
    end
    tick();
    for (int d = 0; d < 4; d++) begin
      if (d == stop_idx) return;
      for (int s = 0; s < 4; s++) begin
        chk("show_en_hi", show_en, 1);
        chk("show_idx", show_idx, d);
        chk("show_digit", show_digit, exp_d[d]);
        chk("show_busy", busy, 1);
        tick();
      end
      for (int g = 0; g < 2; g++) begin
        chk("gap_show_en", show_en, 0);
        chk("gap_show_digit", show_digit, 0);
        chk("gap_busy", busy, 1);
        chk("gap_code_valid", code_valid, 0);
        tick();
      end
    end
    chk("armed_code_valid", code_valid, 1);
    chk("armed_busy", busy, 0);
    chk("num_1", num_1, exp_d[0]);
    chk("num_2", num_2, exp_d[1]);
    chk("num_3", num_3, exp_d[2]);
    chk("num_4", num_4, exp_d[3]);
  endtask

  initial begin
    // 1: reset, then a start pulse and a full display sequence
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    run_round(4);
    chk("num_1_nonzero", num_1 != 3'd0, 1);
    chk("num_2_nonzero", num_2 != 3'd0, 1);
    chk("num_3_nonzero", num_3 != 3'd0, 1);
    chk("num_4_nonzero", num_4 != 3'd0, 1);

    // 2: pass -> one DONE cycle -> GEN with round_cnt bumped
    pass_flag = 1'b1;
    tick();
    pass_flag = 1'b0;
    chk("done_code_valid", code_valid, 0);
    chk("done_busy", busy, 0);
    tick();
    chk("after_done_busy", busy, 1);
    chk("round_cnt_1", round_cnt, 1);
    run_round(4);

    // 3: timeout after 20 armed cycles
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("armed_hold_valid", code_valid, 1);
      chk("armed_no_timeout", timeout_flag, 0);
    end
    tick();
    chk("timeout_pulse", timeout_flag, 1);
    chk("timeout_code_valid", code_valid, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_round_cnt", round_cnt, 1);
    chk("timeout_num_hold", num_1, exp_d[0]);
    tick();
    chk("timeout_one_cycle", timeout_flag, 0);
    chk("idle_stays", busy, 0);

    // 4: pass and start together, pass wins
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    run_round(4);
    pass_flag = 1'b1;
    start = 1'b1;
    tick();
    pass_flag = 1'b0;
    start = 1'b0;
    chk("prio_done_valid", code_valid, 0);
    chk("prio_done_busy", busy, 0);
    chk("prio_no_timeout", timeout_flag, 0);
    tick();
    chk("prio_gen_busy", busy, 1);
    chk("prio_round_cnt", round_cnt, 2);
    chk("prio_gen_no_timeout", timeout_flag, 0);
    run_round(4);

    // 5: drive round_cnt to 255, then confirm saturation
    for (int k = 3; k <= 255; k++) begin
      pass_flag = 1'b1;
      tick();
      pass_flag = 1'b0;
      tick();
      chk("round_cnt_ramp", round_cnt, k);
      run_round(4);
    end
    pass_flag = 1'b1;
    tick();
    pass_flag = 1'b0;
    tick();
    chk("round_cnt_sat", round_cnt, 255);
    run_round(4);

    // 6: start in ARMED regenerates; reset during SHOW of digit 2
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("armed_start_busy", busy, 1);
    chk("armed_start_round_cnt", round_cnt, 255);
    run_round(2);
    chk("mid_show_idx", show_idx, 2);
    chk("mid_show_en", show_en, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk("post_reset_idle", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_reset_busy", busy, 1);
    run_round(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
